// File: rtl/rvx10_exec_unit_if.sv
// Request/response handshake bundle between the operand-read stage and rvx10_exec_unit.
interface rvx10_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output in_valid, alu_ctrl, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, illegal
  );

  modport slave (
    input  in_valid, alu_ctrl, src_a, src_b, out_ready,
    output in_ready, out_valid, result, illegal
  );
endinterface

// File: rtl/rvx10_exec_unit.sv
// RVX10 execution unit: base + RVX10 ALU ops behind valid/ready handshakes.
// RVX10_FAST_ROT_EN selects a one-cycle barrel rotator instead of the iterative one.
module rvx10_exec_unit #(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              reset,
  rvx10_exec_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND  = 4'b0010, OP_OR   = 4'b0011,
    OP_UNDF = 4'b0100, OP_SLT  = 4'b0101, OP_ANDN = 4'b0110, OP_ORN  = 4'b0111,
    OP_XORN = 4'b1000, OP_MIN  = 4'b1001, OP_MAX  = 4'b1010, OP_MINU = 4'b1011,
    OP_MAXU = 4'b1100, OP_ROL  = 4'b1101, OP_ROR  = 4'b1110, OP_ABS  = 4'b1111
  } op_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;
  logic [4:0]      count_q, count_d;
  logic            dir_q, dir_d;
  logic            accept;
  logic            is_rot;
  logic [4:0]      amt;

  function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] c,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (op_t'(c))
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? XLEN'(1) : '0;
      OP_ANDN: r = a & ~b;
      OP_ORN:  r = a | ~b;
      OP_XORN: r = a ^ ~b;
      OP_MIN:  r = ($signed(a) < $signed(b)) ? a : b;
      OP_MAX:  r = ($signed(a) > $signed(b)) ? a : b;
      OP_MINU: r = (a < b) ? a : b;
      OP_MAXU: r = (a > b) ? a : b;
      OP_ABS:  r = a[XLEN-1] ? ('0 - a) : a;
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef RVX10_FAST_ROT_EN
  function automatic logic [XLEN-1:0] barrel_rot(input logic right,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [4:0] n);
    logic [2*XLEN-1:0] dbl;
    dbl = {a, a};
    if (right) dbl = dbl >> n;
    else       dbl = dbl << n;
    return right ? dbl[XLEN-1:0] : dbl[2*XLEN-1:XLEN];
  endfunction
`endif

  assign is_rot = (bus.alu_ctrl == OP_ROL) || (bus.alu_ctrl == OP_ROR);
  assign amt    = bus.src_b[4:0];

  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    illegal_d    = illegal_q;
    count_d      = count_q;
    dir_d        = dir_q;
    bus.in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    accept       = bus.in_valid && bus.in_ready;

    case (state_q)
      ROT: begin
        // result_q doubles as the rotate accumulator; out_valid is low meanwhile
        result_d = dir_q ? {result_q[0], result_q[XLEN-1:1]}
                         : {result_q[XLEN-2:0], result_q[XLEN-1]};
        count_d  = count_q - 5'd1;
        if (count_q == 5'd1) state_d = DONE;
      end
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: ;
    endcase

    if (accept) begin
      state_d   = DONE;
      illegal_d = (bus.alu_ctrl == OP_UNDF);
      if (is_rot) begin
`ifdef RVX10_FAST_ROT_EN
        result_d = barrel_rot(bus.alu_ctrl == OP_ROR, bus.src_a, amt);
`else
        result_d = bus.src_a;
        if (amt != 5'd0) begin
          count_d = amt;
          dir_d   = (bus.alu_ctrl == OP_ROR);
          state_d = ROT;
        end
`endif
      end else begin
        result_d = alu_calc(bus.alu_ctrl, bus.src_a, bus.src_b);
      end
    end

    bus.out_valid = (state_q == DONE);
    bus.result    = result_q;
    bus.illegal   = illegal_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
    end
  end

endmodule

// File: tb/tb_rvx10_exec_unit.sv
// Self-checking bench for rvx10_exec_unit: directed vector table, handshake corner
// sequences and randomized ops against an arithmetic reference model.
module tb_rvx10_exec_unit;

  logic clk;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  rvx10_exec_unit_if #(.XLEN(32)) bus ();

  rvx10_exec_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected latency from the accept edge to first out_valid.
  function automatic int unsigned exp_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef RVX10_FAST_ROT_EN
    return 1;
`else
    if ((c == 4'd13 || c == 4'd14) && (b % 32) != 0) return (b % 32) + 1;
    return 1;
`endif
  endfunction

  // Reference model: {illegal, result} from plain integer arithmetic.
  function automatic logic [32:0] ref_op(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub, m, x;
    int n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    m  = longint'(1) << 32;
    n  = int'(b % 32);
    x  = 0;
    case (c)
      4'd0:  x = (ua + ub) % m;
      4'd1:  x = (ua - ub + m) % m;
      4'd2:  x = longint'(a & b);
      4'd3:  x = longint'(a | b);
      4'd4:  return {1'b1, 32'd0};
      4'd5:  x = (sa < sb) ? 1 : 0;
      4'd6:  x = longint'(a & ~b);
      4'd7:  x = longint'(a | ~b);
      4'd8:  x = longint'(a ^ ~b);
      4'd9:  x = (sa < sb) ? ua : ub;
      4'd10: x = (sa > sb) ? ua : ub;
      4'd11: x = (ua < ub) ? ua : ub;
      4'd12: x = (ua > ub) ? ua : ub;
      4'd13: x = ((ua * (longint'(1) << n)) % m) + ua / (longint'(1) << (32 - n));
      4'd14: x = ua / (longint'(1) << n) + (ua % (longint'(1) << n)) * (longint'(1) << (32 - n));
      default: x = (sa < 0) ? (m - ua) % m : ua;
    endcase
    return {1'b0, 32'(x)};
  endfunction

  // Issue one request, wait for its result (bounded), optionally stall, then drain.
  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input int unsigned stall, input string tag,
                       output logic [31:0] r, output logic ill, output int unsigned lat,
                       output logic rot_ready);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.alu_ctrl  = c;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.out_ready = (stall == 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.alu_ctrl = ~c;
    bus.src_a    = ~a;
    bus.src_b    = ~b;
    lat       = 1;
    rot_ready = 1'b0;
    while (!bus.out_valid && lat < 64) begin
      if (bus.in_ready) rot_ready = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    r   = bus.result;
    ill = bus.illegal;
    for (int unsigned k = 0; k < stall; k++) begin
      @(posedge clk);
      #1;
      chk({tag, " stall result"}, bus.result, r);
      chk({tag, " stall in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    if (stall > 0) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, " drained"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic        ill;
    logic        rrdy;
    logic [32:0] m;
    int unsigned lat;
    logic [3:0]  c;
    logic [31:0] a, b;

    vecs[0]  = '{4'h0, 32'd2,         32'd3,         32'd5,         1'b0};
    vecs[1]  = '{4'h0, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b0};
    vecs[2]  = '{4'h1, 32'd5,         32'd7,         32'hFFFFFFFE,  1'b0};
    vecs[3]  = '{4'h2, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  1'b0};
    vecs[4]  = '{4'h3, 32'hF0F0F0F0,  32'h0F000000,  32'hFFF0F0F0,  1'b0};
    vecs[5]  = '{4'h5, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0};
    vecs[6]  = '{4'h5, 32'd1,         32'hFFFFFFFF,  32'd0,         1'b0};
    vecs[7]  = '{4'h6, 32'hF0F0F0F0,  32'hFF00FF00,  32'h00F000F0,  1'b0};
    vecs[8]  = '{4'h7, 32'h12340000,  32'hFFFF0000,  32'h1234FFFF,  1'b0};
    vecs[9]  = '{4'h8, 32'hAAAAAAAA,  32'h0F0F0F0F,  32'h5A5A5A5A,  1'b0};
    vecs[10] = '{4'h9, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  1'b0};
    vecs[11] = '{4'hA, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0};
    vecs[12] = '{4'hB, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0};
    vecs[13] = '{4'hC, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  1'b0};
    vecs[14] = '{4'hD, 32'h80000001,  32'h00000025,  32'h00000030,  1'b0};
    vecs[15] = '{4'hE, 32'h80000001,  32'h00000020,  32'h80000001,  1'b0};
    vecs[16] = '{4'hE, 32'h00000001,  32'd1,         32'h80000000,  1'b0};
    vecs[17] = '{4'hF, 32'h80000000,  32'd0,         32'h80000000,  1'b0};
    vecs[18] = '{4'hF, 32'hFFFFFFF6,  32'd0,         32'h0000000A,  1'b0};
    vecs[19] = '{4'h4, 32'h12345678,  32'h9ABCDEF0,  32'd0,         1'b1};

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = '0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset result", bus.result, 32'd0);
    chk("reset illegal", {31'd0, bus.illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      do_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, i % 3, $sformatf("vec%0d", i), r, ill, lat, rrdy);
      chk($sformatf("vec%0d result", i), r, vecs[i].res);
      chk($sformatf("vec%0d illegal", i), {31'd0, ill}, {31'd0, vecs[i].ill});
      chk($sformatf("vec%0d latency", i), lat, exp_lat(vecs[i].ctrl, vecs[i].b));
      chk($sformatf("vec%0d in_ready busy", i), {31'd0, rrdy}, 32'd0);
    end

    // Back-to-back min then minu with out_ready held high.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_ctrl = 4'h9; bus.src_a = 32'hFFFFFFFF; bus.src_b = 32'd1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.alu_ctrl = 4'hB;
    chk("b2b min valid", {31'd0, bus.out_valid}, 32'd1);
    chk("b2b min result", bus.result, 32'hFFFFFFFF);
    chk("b2b in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("b2b minu valid", {31'd0, bus.out_valid}, 32'd1);
    chk("b2b minu result", bus.result, 32'd1);
    @(posedge clk);
    #1;
    chk("b2b drained", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure for 10 cycles, then consume and accept on the same edge.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_ctrl = 4'h0; bus.src_a = 32'h10; bus.src_b = 32'h20;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.src_a = 32'h777;
    chk("bp valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp result", bus.result, 32'h30);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp hold result", bus.result, 32'h30);
      chk("bp hold in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp hold valid", {31'd0, bus.out_valid}, 32'd1);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.alu_ctrl = 4'h8; bus.src_a = 32'd0; bus.src_b = 32'd0;
    #1;
    chk("bp release in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp next result", bus.result, 32'hFFFFFFFF);
    chk("bp next valid", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk("bp drained", {31'd0, bus.out_valid}, 32'd0);

    // Reset during the 10th ROT cycle of a rotate by 31.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_ctrl = 4'hE; bus.src_a = 32'h12345678; bus.src_b = 32'd31;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
`ifndef RVX10_FAST_ROT_EN
    chk("rot busy in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rot busy valid", {31'd0, bus.out_valid}, 32'd0);
`endif
    #2;
    reset = 1'b0;
    #1;
    chk("abort valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort result", bus.result, 32'd0);
    chk("abort illegal", {31'd0, bus.illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    do_op(4'h0, 32'd2, 32'd3, 0, "post reset", r, ill, lat, rrdy);
    chk("post reset result", r, 32'd5);
    chk("post reset latency", lat, 32'd1);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) a = {a[31], 31'd0};
      m = ref_op(c, a, b);
      do_op(c, a, b, $urandom_range(0, 3), $sformatf("rnd%0d", i), r, ill, lat, rrdy);
      chk($sformatf("rnd%0d result op%0d", i, c), r, m[31:0]);
      chk($sformatf("rnd%0d illegal", i), {31'd0, ill}, {31'd0, m[32]});
      chk($sformatf("rnd%0d latency", i), lat, exp_lat(c, b));
      chk($sformatf("rnd%0d in_ready busy", i), {31'd0, rrdy}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
